// File: rtl/reg_bus_master.sv
// rtl/reg_bus_master.sv - host byte-stream command parser driving single-beat register bus accesses
// Optional inter-byte timeout: define REG_BUS_MASTER_TIMEOUT_EN.
module reg_bus_master #(
  parameter logic [7:0] SYNC_BYTE = 8'h55,
  parameter logic [7:0] RESP_BYTE = 8'hAA
`ifdef REG_BUS_MASTER_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 50000
`endif
) (
  input  logic        ipClk,
  input  logic        ipReset,
  input  logic [7:0]  ipRxData,
  input  logic        ipRxValid,
  output logic        opRxReady,
  output logic [7:0]  opTxData,
  output logic        opTxValid,
  input  logic        ipTxReady,
  output logic [7:0]  opAddress,
  output logic [31:0] opWrData,
  output logic        opWrEnable,
  input  logic [31:0] ipRdData,
  output logic [7:0]  opErrorCount
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_WDATA, S_WRITE, S_RD_WAIT, S_RD_CAP, S_RESP
  } state_t;

  state_t      state_q;
  logic [7:0]  addr_q;
  logic [31:0] wr_data_q;
  logic        wr_en_q;
  logic [7:0]  tx_data_q;
  logic        tx_valid_q;
  logic        rx_ready_q;
  logic [7:0]  err_cnt_q;
  logic [1:0]  byte_cnt_q;
  logic [2:0]  resp_idx_q;
  logic [31:0] resp_q;
  logic        is_read_q;

  logic       rx_fire;
  logic       tx_fire;
  logic [7:0] err_cnt_inc;
  logic       timeout_hit;

  assign rx_fire     = ipRxValid && rx_ready_q;
  assign tx_fire     = tx_valid_q && ipTxReady;
  assign err_cnt_inc = (err_cnt_q == 8'hFF) ? 8'hFF : err_cnt_q + 8'd1;

  function automatic logic [7:0] resp_byte(input logic [2:0] idx, input logic [7:0] a,
                                           input logic [31:0] d);
    case (idx)
      3'd0:    resp_byte = RESP_BYTE;
      3'd1:    resp_byte = a;
      3'd2:    resp_byte = d[7:0];
      3'd3:    resp_byte = d[15:8];
      3'd4:    resp_byte = d[23:16];
      default: resp_byte = d[31:24];
    endcase
  endfunction

`ifdef REG_BUS_MASTER_TIMEOUT_EN
  logic [31:0] idle_cnt_q;
  logic        in_pkt;

  assign in_pkt      = (state_q == S_CMD) || (state_q == S_ADDR) || (state_q == S_WDATA);
  assign timeout_hit = in_pkt && !rx_fire && (idle_cnt_q == TIMEOUT_CYCLES - 1);

  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset)                            idle_cnt_q <= '0;
    else if (!in_pkt || rx_fire || timeout_hit) idle_cnt_q <= '0;
    else                                     idle_cnt_q <= idle_cnt_q + 32'd1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // rx_ready_q is set for the state being entered so it is correct from the first cycle there.
  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wr_data_q  <= '0;
      wr_en_q    <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      rx_ready_q <= 1'b0;
      err_cnt_q  <= '0;
      byte_cnt_q <= '0;
      resp_idx_q <= '0;
      resp_q     <= '0;
      is_read_q  <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      if (timeout_hit) begin
        state_q    <= S_IDLE;
        err_cnt_q  <= err_cnt_inc;
        byte_cnt_q <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            rx_ready_q <= 1'b1;
            if (rx_fire && ipRxData == SYNC_BYTE) state_q <= S_CMD;
          end
          S_CMD: if (rx_fire) begin
            if (ipRxData == 8'h01 || ipRxData == 8'h02) begin
              is_read_q <= ipRxData[1];
              state_q   <= S_ADDR;
            end else begin
              state_q   <= S_IDLE;
              err_cnt_q <= err_cnt_inc;
            end
          end
          S_ADDR: if (rx_fire) begin
            addr_q     <= ipRxData;
            byte_cnt_q <= '0;
            if (is_read_q) begin
              state_q    <= S_RD_WAIT;
              rx_ready_q <= 1'b0;
            end else begin
              state_q    <= S_WDATA;
            end
          end
          S_WDATA: if (rx_fire) begin
            wr_data_q  <= {ipRxData, wr_data_q[31:8]};
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              state_q    <= S_WRITE;
              wr_en_q    <= 1'b1;
              rx_ready_q <= 1'b0;
            end
          end
          S_WRITE: begin
            state_q    <= S_IDLE;
            rx_ready_q <= 1'b1;
          end
          S_RD_WAIT: state_q <= S_RD_CAP;
          S_RD_CAP: begin
            resp_q     <= ipRdData;
            tx_data_q  <= RESP_BYTE;
            tx_valid_q <= 1'b1;
            resp_idx_q <= '0;
            state_q    <= S_RESP;
          end
          S_RESP: if (tx_fire) begin
            if (resp_idx_q == 3'd5) begin
              tx_valid_q <= 1'b0;
              resp_idx_q <= '0;
              rx_ready_q <= 1'b1;
              state_q    <= S_IDLE;
            end else begin
              resp_idx_q <= resp_idx_q + 3'd1;
              tx_data_q  <= resp_byte(resp_idx_q + 3'd1, addr_q, resp_q);
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign opRxReady    = rx_ready_q;
  assign opTxData     = tx_data_q;
  assign opTxValid    = tx_valid_q;
  assign opAddress    = addr_q;
  assign opWrData     = wr_data_q;
  assign opWrEnable   = wr_en_q;
  assign opErrorCount = err_cnt_q;

endmodule
